mul_rs_dispatch: RTL and testbench

- Multiply/divide reservation station and dispatcher.
- Accepts issued MUL/DIV ops from the issue stage. Holds up to NUM_RS entries and snoops the common data bus (CDB) for pending operand tags.
- Launches ready ops to the NUM_FU multiplier units through their fla/data1/data2/des/fun3 interface.
- Frees an entry and its unit when that unit reports completion.

---
 rtl/mul_rs_dispatch_pkg.sv | 17 +
 rtl/mul_rs_dispatch_prio_pick.sv | 27 ++
 rtl/mul_rs_dispatch.sv | 183 ++++++++++++++++++
 tb/tb_mul_rs_dispatch.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_rs_dispatch_pkg.sv
// Shared widths, function codes and entry-state encoding for the MUL/DIV reservation station.
package mul_rs_dispatch_pkg;

  localparam int unsigned TAG_W  = 3;
  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] FUN_MUL = 3'd0;
  localparam logic [2:0] FUN_DIV = 3'd1;

  typedef enum logic [1:0] {
    StFree  = 2'd0,
    StWait  = 2'd1,
    StReady = 2'd2,
    StExec  = 2'd3
  } rs_state_e;

endpackage

// File: rtl/mul_rs_dispatch_prio_pick.sv
// Lowest-index picker: one-hot grant, binary index and an any-request flag.
module prio_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  output logic [N-1:0]    onehot,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    // Scan downwards so the lowest set bit is the one left standing.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IdxW'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_rs_dispatch.sv
// Multiply/divide reservation station: holds issued ops, snoops the CDB for operands,
// launches ready ops onto idle multiplier units and frees entries on unit completion.
module mul_rs_dispatch #(
  parameter int unsigned NUM_RS = 3,
  parameter int unsigned NUM_FU = 3,
  parameter int unsigned TAG_W  = mul_rs_dispatch_pkg::TAG_W,
  parameter int unsigned DATA_W = mul_rs_dispatch_pkg::DATA_W
) (
  input  logic                       clk1,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [2:0]                 issue_fun3,
  input  logic [TAG_W-1:0]           issue_des,
  input  logic [DATA_W-1:0]          issue_val1,
  input  logic [DATA_W-1:0]          issue_val2,
  input  logic                       issue_rdy1,
  input  logic                       issue_rdy2,
  input  logic [TAG_W-1:0]           issue_tag1,
  input  logic [TAG_W-1:0]           issue_tag2,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  output logic [NUM_FU-1:0]          fla,
  output logic [NUM_FU*DATA_W-1:0]   fu_data1,
  output logic [NUM_FU*DATA_W-1:0]   fu_data2,
  output logic [NUM_FU*TAG_W-1:0]    fu_des,
  output logic [NUM_FU*3-1:0]        fu_fun3,
  input  logic [NUM_FU-1:0]          fu_done,
  output logic [$clog2(NUM_RS+1)-1:0] occupancy
);
  import mul_rs_dispatch_pkg::*;

  localparam int unsigned FuIdxW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned RsIdxW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int unsigned OccW   = $clog2(NUM_RS + 1);

  typedef struct packed {
    rs_state_e          state;
    logic [2:0]         fun3;
    logic [TAG_W-1:0]   des;
    logic               rdy1;
    logic               rdy2;
    logic [TAG_W-1:0]   tag1;
    logic [TAG_W-1:0]   tag2;
    logic [DATA_W-1:0]  val1;
    logic [DATA_W-1:0]  val2;
    logic [FuIdxW-1:0]  fu;
  } entry_t;

  entry_t ent_q [NUM_RS];
  entry_t ent_d [NUM_RS];

  logic [NUM_FU-1:0]        busy_q, fla_q, done_eff;
  logic [NUM_FU*DATA_W-1:0] data1_q, data2_q;
  logic [NUM_FU*TAG_W-1:0]  des_q;
  logic [NUM_FU*3-1:0]      fun3_q;

  logic [NUM_RS-1:0] free_vec, ready_vec, free_oh, ready_oh;
  logic [RsIdxW-1:0] free_idx, ready_idx;
  logic [NUM_FU-1:0] unit_oh;
  logic [FuIdxW-1:0] unit_idx;
  logic              free_any, ready_any, unit_any, dispatch, issue_fire;
  logic              byp1, byp2, rdy1_in, rdy2_in;
  logic [DATA_W-1:0] val1_in, val2_in;
  logic [OccW-1:0]   occ;

  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < int'(NUM_RS); i++) begin
      free_vec[i]  = (ent_q[i].state == StFree);
      ready_vec[i] = (ent_q[i].state == StReady);
    end
  end

  prio_pick #(.N(NUM_RS)) u_free_pick (
    .req(free_vec), .onehot(free_oh), .idx(free_idx), .any(free_any)
  );
  prio_pick #(.N(NUM_RS)) u_ready_pick (
    .req(ready_vec), .onehot(ready_oh), .idx(ready_idx), .any(ready_any)
  );
  prio_pick #(.N(NUM_FU)) u_unit_pick (
    .req(~busy_q), .onehot(unit_oh), .idx(unit_idx), .any(unit_any)
  );

  logic unused_free_idx;
  assign unused_free_idx = ^free_idx;

  assign issue_ready = free_any;
  assign issue_fire  = issue_valid & free_any;
  assign dispatch    = ready_any & unit_any;
  // A done pulse for an idle unit (e.g. after flush) must not free anything.
  assign done_eff    = fu_done & busy_q;

  // Same-cycle CDB bypass for operands that are not yet available at issue.
  assign byp1    = !issue_rdy1 && cdb_valid && (cdb_tag == issue_tag1);
  assign byp2    = !issue_rdy2 && cdb_valid && (cdb_tag == issue_tag2);
  assign rdy1_in = issue_rdy1 | byp1;
  assign rdy2_in = issue_rdy2 | byp2;
  assign val1_in = byp1 ? cdb_data : issue_val1;
  assign val2_in = byp2 ? cdb_data : issue_val2;

  always_comb begin
    for (int i = 0; i < int'(NUM_RS); i++) begin
      ent_d[i] = ent_q[i];
      unique case (ent_q[i].state)
        StFree: begin
          if (issue_fire && free_oh[i]) begin
            ent_d[i].fun3  = issue_fun3;
            ent_d[i].des   = issue_des;
            ent_d[i].rdy1  = rdy1_in;
            ent_d[i].rdy2  = rdy2_in;
            ent_d[i].tag1  = issue_tag1;
            ent_d[i].tag2  = issue_tag2;
            ent_d[i].val1  = val1_in;
            ent_d[i].val2  = val2_in;
            ent_d[i].state = (rdy1_in && rdy2_in) ? StReady : StWait;
          end
        end
        StWait: begin
          if (!ent_q[i].rdy1 && cdb_valid && (cdb_tag == ent_q[i].tag1)) begin
            ent_d[i].rdy1 = 1'b1;
            ent_d[i].val1 = cdb_data;
          end
          if (!ent_q[i].rdy2 && cdb_valid && (cdb_tag == ent_q[i].tag2)) begin
            ent_d[i].rdy2 = 1'b1;
            ent_d[i].val2 = cdb_data;
          end
          if (ent_d[i].rdy1 && ent_d[i].rdy2) ent_d[i].state = StReady;
        end
        StReady: begin
          if (dispatch && ready_oh[i]) begin
            ent_d[i].state = StExec;
            ent_d[i].fu    = unit_idx;
          end
        end
        StExec: begin
          if (done_eff[ent_q[i].fu]) ent_d[i].state = StFree;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (rst || flush) begin
      for (int i = 0; i < int'(NUM_RS); i++) ent_q[i] <= '0;
      busy_q  <= '0;
      fla_q   <= '0;
      data1_q <= '0;
      data2_q <= '0;
      des_q   <= '0;
      fun3_q  <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_RS); i++) ent_q[i] <= ent_d[i];
      busy_q <= (busy_q & ~done_eff) | (dispatch ? unit_oh : '0);
      fla_q  <= dispatch ? unit_oh : '0;
      if (dispatch) begin
        data1_q[unit_idx*DATA_W +: DATA_W] <= ent_q[ready_idx].val1;
        data2_q[unit_idx*DATA_W +: DATA_W] <= ent_q[ready_idx].val2;
        des_q[unit_idx*TAG_W +: TAG_W]     <= ent_q[ready_idx].des;
        fun3_q[unit_idx*3 +: 3]            <= ent_q[ready_idx].fun3;
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < int'(NUM_RS); i++) begin
      if (ent_q[i].state != StFree) occ = occ + OccW'(1);
    end
  end

  assign occupancy = occ;
  assign fla       = fla_q;
  assign fu_data1  = data1_q;
  assign fu_data2  = data2_q;
  assign fu_des    = des_q;
  assign fu_fun3   = fun3_q;

endmodule

// File: tb/tb_mul_rs_dispatch.sv
// Directed, table-driven bench for mul_rs_dispatch with hand-written reset/flush sequences.
module tb_mul_rs_dispatch;

  logic        clk1 = 1'b0;
  logic        rst, flush, issue_valid, issue_ready;
  logic [2:0]  issue_fun3, issue_des, issue_tag1, issue_tag2;
  logic [31:0] issue_val1, issue_val2;
  logic        issue_rdy1, issue_rdy2, cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [2:0]  fla, fu_done;
  logic [95:0] fu_data1, fu_data2;
  logic [8:0]  fu_des, fu_fun3;
  logic [1:0]  occupancy;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk1 = ~clk1;

  mul_rs_dispatch dut (
    .clk1(clk1), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_fun3(issue_fun3),
    .issue_des(issue_des), .issue_val1(issue_val1), .issue_val2(issue_val2),
    .issue_rdy1(issue_rdy1), .issue_rdy2(issue_rdy2),
    .issue_tag1(issue_tag1), .issue_tag2(issue_tag2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .fla(fla), .fu_data1(fu_data1), .fu_data2(fu_data2), .fu_des(fu_des),
    .fu_fun3(fu_fun3), .fu_done(fu_done), .occupancy(occupancy)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [2:0]  fun;
    logic [2:0]  des;
    logic [31:0] v1, v2;
    logic        r1, r2;
    logic [2:0]  t1, t2;
    logic        cv;
    logic [2:0]  ct;
    logic [31:0] cd;
    logic [2:0]  done;
    logic [2:0]  efla;
    logic        erdy;
    logic [1:0]  eocc;
    int          cku;
    logic [31:0] ed1, ed2;
    logic [2:0]  edes, efun;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t row(int rs, int iv, int fun, int des, int v1, int v2, int r1,
                               int r2, int t1, int t2, int cv, int ct, int cd, int done,
                               int efla, int erdy, int eocc, int cku, int ed1, int ed2,
                               int edes, int efun);
    vec_t v;
    v.rst = rs[0]; v.iv = iv[0]; v.fun = fun[2:0]; v.des = des[2:0];
    v.v1 = v1; v.v2 = v2; v.r1 = r1[0]; v.r2 = r2[0]; v.t1 = t1[2:0]; v.t2 = t2[2:0];
    v.cv = cv[0]; v.ct = ct[2:0]; v.cd = cd; v.done = done[2:0];
    v.efla = efla[2:0]; v.erdy = erdy[0]; v.eocc = eocc[1:0]; v.cku = cku;
    v.ed1 = ed1; v.ed2 = ed2; v.edes = edes[2:0]; v.efun = efun[2:0];
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    @(negedge clk1);
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; issue_valid = 0; issue_fun3 = 0; issue_des = 0;
    issue_val1 = 0; issue_val2 = 0; issue_rdy1 = 0; issue_rdy2 = 0;
    issue_tag1 = 0; issue_tag2 = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0; fu_done = 0;
  endtask

  task automatic issue(input int fun, input int des, input int v1, input int v2,
                       input int r1, input int r2, input int t1, input int t2);
    issue_valid = 1; issue_fun3 = fun[2:0]; issue_des = des[2:0];
    issue_val1 = v1; issue_val2 = v2; issue_rdy1 = r1[0]; issue_rdy2 = r2[0];
    issue_tag1 = t1[2:0]; issue_tag2 = t2[2:0];
  endtask

  initial begin
    // rs iv fn ds v1 v2 r1 r2 t1 t2 cv ct cd done | efla erdy eocc cku ed1 ed2 edes efun
    vq.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(row(0, 1, 0, 2, 6, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, -1, 0, 0, 0, 0));
    vq.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 6, 7, 2, 0));
    vq.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 6, 7, 2, 0));
    vq.push_back(row(0, 1, 1, 4, 0, 3, 0, 1, 5, 0, 0, 0, 0, 0, 0, 1, 1, -1, 0, 0, 0, 0));
    vq.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, -1, 0, 0, 0, 0));
    vq.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 99, 0, 0, 1, 1, -1, 0, 0, 0, 0));
    vq.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 99, 3, 4, 1));
    vq.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, -1, 0, 0, 0, 0));
    vq.push_back(row(0, 1, 0, 1, 0, 5, 0, 1, 6, 0, 1, 6, 11, 0, 0, 1, 1, -1, 0, 0, 0, 0));
    vq.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 11, 5, 1, 0));
    vq.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, -1, 0, 0, 0, 0));
    vq.push_back(row(0, 1, 0, 0, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, -1, 0, 0, 0, 0));
    vq.push_back(row(0, 1, 0, 1, 3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 1, 2, 0, 0));
    vq.push_back(row(0, 1, 0, 2, 5, 6, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 3, 1, 3, 4, 1, 0));
    vq.push_back(row(0, 1, 0, 7, 8, 9, 1, 1, 0, 0, 0, 0, 0, 0, 4, 0, 3, 2, 5, 6, 2, 0));
    vq.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, -1, 0, 0, 0, 0));
    vq.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 2, -1, 0, 0, 0, 0));
    vq.push_back(row(0, 1, 1, 3, 10, 20, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, -1, 0, 0, 0, 0));
    vq.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 3, 1, 10, 20, 3, 1));
    vq.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 1, 2, -1, 0, 0, 0, 0));
    vq.push_back(row(0, 1, 0, 5, 7, 8, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 2, -1, 0, 0, 0, 0));
    vq.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 7, 8, 5, 0));
    vq.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, -1, 0, 0, 0, 0));
    vq.push_back(row(0, 1, 1, 6, 0, 0, 0, 0, 3, 3, 1, 4, 1, 0, 0, 1, 2, -1, 0, 0, 0, 0));
    vq.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 42, 0, 0, 1, 2, -1, 0, 0, 0, 0));
    vq.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 42, 42, 6, 1));

    idle_inputs();
    foreach (vq[i]) begin
      vec_t v;
      v = vq[i];
      rst = v.rst; flush = 0; issue_valid = v.iv; issue_fun3 = v.fun; issue_des = v.des;
      issue_val1 = v.v1; issue_val2 = v.v2; issue_rdy1 = v.r1; issue_rdy2 = v.r2;
      issue_tag1 = v.t1; issue_tag2 = v.t2; cdb_valid = v.cv; cdb_tag = v.ct;
      cdb_data = v.cd; fu_done = v.done;
      step();
      check($sformatf("r%0d fla", i), 64'(fla), 64'(v.efla));
      check($sformatf("r%0d issue_ready", i), 64'(issue_ready), 64'(v.erdy));
      check($sformatf("r%0d occupancy", i), 64'(occupancy), 64'(v.eocc));
      if (v.cku >= 0) begin
        check($sformatf("r%0d data1[%0d]", i, v.cku), 64'(fu_data1[v.cku*32 +: 32]),
              64'(v.ed1));
        check($sformatf("r%0d data2[%0d]", i, v.cku), 64'(fu_data2[v.cku*32 +: 32]),
              64'(v.ed2));
        check($sformatf("r%0d des/fun3[%0d]", i, v.cku),
              64'({fu_des[v.cku*3 +: 3], fu_fun3[v.cku*3 +: 3]}), 64'({v.edes, v.efun}));
      end
    end

    // Reset with two entries executing and one waiting; late fu_done must be inert.
    idle_inputs();
    issue(1, 1, 0, 0, 0, 1, 7, 0);
    step();
    check("rst_pre occupancy", 64'(occupancy), 64'd3);
    check("rst_pre issue_ready", 64'(issue_ready), 64'd0);
    idle_inputs();
    rst = 1;
    step();
    check("rst occupancy", 64'(occupancy), 64'd0);
    check("rst fla", 64'(fla), 64'd0);
    check("rst issue_ready", 64'(issue_ready), 64'd1);
    check("rst fu_data1", 64'(fu_data1[63:0]), 64'd0);
    check("rst fu_des", 64'(fu_des), 64'd0);
    idle_inputs();
    fu_done = 3'b001;
    step();
    check("late_done occupancy", 64'(occupancy), 64'd0);
    check("late_done fla", 64'(fla), 64'd0);
    check("late_done issue_ready", 64'(issue_ready), 64'd1);
    idle_inputs();
    cdb_valid = 1; cdb_tag = 7; cdb_data = 5;
    step();
    check("stale_cdb fla", 64'(fla), 64'd0);
    check("stale_cdb occupancy", 64'(occupancy), 64'd0);
    idle_inputs();
    issue(0, 3, 2, 3, 1, 1, 0, 0);
    step();
    check("post_rst issue occupancy", 64'(occupancy), 64'd1);
    check("post_rst issue fla", 64'(fla), 64'd0);
    idle_inputs();
    step();
    check("post_rst dispatch fla", 64'(fla), 64'b001);
    check("post_rst dispatch data2", 64'(fu_data2[31:0]), 64'd3);

    // Flush in the cycle a ready entry would dispatch.
    idle_inputs();
    issue(0, 4, 9, 9, 1, 1, 0, 0);
    step();
    check("flush_pre occupancy", 64'(occupancy), 64'd2);
    idle_inputs();
    flush = 1;
    step();
    check("flush fla", 64'(fla), 64'd0);
    check("flush occupancy", 64'(occupancy), 64'd0);
    check("flush issue_ready", 64'(issue_ready), 64'd1);
    idle_inputs();
    fu_done = 3'b001;
    step();
    check("flush_after fla", 64'(fla), 64'd0);
    check("flush_after occupancy", 64'(occupancy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
